// File: rtl/regfile_mp.sv
// Multi-read-port register file with busy scoreboard and sequenced clear after reset.
// Reads are combinational (zero latency); writes and scoreboard updates land on the clock edge.
// No backpressure; we/sb_set are ignored until init_done. REGFILE_MP_BYPASS_EN adds write-to-read bypass.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int REGS     = 32,
  parameter int RPORTS   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic [RPORTS*AW-1:0]     ra,
  output logic [RPORTS*WIDTH-1:0]  rd,
  output logic [RPORTS-1:0]        rbusy,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      cnt;
  logic [WIDTH-1:0]   mem [REGS];
  logic [REGS-1:0]    sb;
  logic               run, cnt_last, wr_en, sb_en;

  assign run       = (state == RUN);
  assign init_done = run;
  assign cnt_last  = (cnt == AW'(REGS - 1));

  // Register 0 is only suppressed when it is hardwired to zero.
  assign wr_en = run && we && (int'(wa) < REGS) && !((ZERO_REG != 0) && (wa == '0));
  assign sb_en = run && sb_set && (int'(sb_addr) < REGS) && !((ZERO_REG != 0) && (sb_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt_last) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst)                          cnt <= '0;
    else if (state == CLEAR && !cnt_last) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr_en)     mem[wa]  <= wd;
    end
  end

  // A same-cycle set overrides the clear: a newer producer is still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else begin
      if (wr_en) sb[wa]      <= 1'b0;
      if (sb_en) sb[sb_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < RPORTS; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = ra[i*AW +: AW];
    assign hit = run && (int'(a) < REGS) && !((ZERO_REG != 0) && (a == '0));
`ifdef REGFILE_MP_BYPASS_EN
    logic byp;
    assign byp = wr_en && (wa == a);
    assign rd[i*WIDTH +: WIDTH] = !hit ? '0 : (byp ? wd : mem[a]);
    assign rbusy[i] = hit && (byp ? (sb_en && (sb_addr == a)) : sb[a]);
`else
    assign rd[i*WIDTH +: WIDTH] = hit ? mem[a] : '0;
    assign rbusy[i] = hit && sb[a];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: REGS=32, RPORTS=3, ZERO_REG=1.
module tb_regfile_mp;
  localparam int W  = 32;
  localparam int R  = 32;
  localparam int P  = 3;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst, init_done, we, sb_set;
  logic [AW-1:0]   wa, sb_addr;
  logic [W-1:0]    wd;
  logic [P*AW-1:0] ra;
  logic [P*W-1:0]  rd;
  logic [P-1:0]    rbusy;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(W), .REGS(R), .RPORTS(P), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd), .rbusy(rbusy), .sb_set(sb_set), .sb_addr(sb_addr)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic          sb_set;
    logic [AW-1:0] sb_addr;
    logic [P*AW-1:0] ra;
    logic [P*W-1:0]  erd;
    logic [P-1:0]    ebusy;
  } vec_t;

  vec_t vt[13];
  int passed = 0;
  int total  = 0;

  function automatic logic [P*AW-1:0] pk(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [P*W-1:0] pd(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                        input logic [W-1:0] d2);
    return {d2, d1, d0};
  endfunction

  function automatic vec_t mk(input logic w, input int a, input logic [W-1:0] d,
                              input logic s, input int sa, input logic [P*AW-1:0] r,
                              input logic [P*W-1:0] e, input logic [P-1:0] eb);
    vec_t v;
    v.we = w; v.wa = AW'(a); v.wd = d; v.sb_set = s; v.sb_addr = AW'(sa);
    v.ra = r; v.erd = e; v.ebusy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [P*W-1:0] act, input logic [P*W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name, input int exp);
    int n = 0;
    while (!init_done && n < 100) begin
      step();
      n++;
    end
    chk(name, P*W'(n), P*W'(exp));
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; sb_set = 1'b0; sb_addr = '0; ra = '0;

    vt[0]  = mk(1, 7, 32'h12345678, 0, 0, pk(0,0,0), '0, 3'b000);
    vt[1]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, pk(7,0,7), pd(32'h12345678, 0, 32'h12345678), 3'b000);
    vt[2]  = mk(0, 0, 0,            0, 0, pk(0,7,0), pd(0, 32'h12345678, 0), 3'b000);
    vt[3]  = mk(0, 0, 0,            1, 9, pk(9,0,0), '0, 3'b000);
    vt[4]  = mk(0, 0, 0,            0, 0, pk(9,9,7), pd(0, 0, 32'h12345678), 3'b011);
    vt[5]  = mk(0, 0, 0,            0, 0, pk(0,9,0), '0, 3'b010);
    vt[6]  = mk(1, 9, 32'hA5,       0, 0, pk(7,7,7), pd(32'h12345678, 32'h12345678, 32'h12345678), 3'b000);
    vt[7]  = mk(0, 0, 0,            0, 0, pk(9,9,9), pd(32'hA5, 32'hA5, 32'hA5), 3'b000);
    vt[8]  = mk(1, 4, 32'h11,       1, 4, pk(0,0,0), '0, 3'b000);
    vt[9]  = mk(0, 0, 0,            0, 0, pk(4,0,4), pd(32'h11, 0, 32'h11), 3'b101);
    vt[10] = mk(0, 0, 0,            1, 0, pk(0,0,0), '0, 3'b000);
    vt[11] = mk(1, 11, 32'h22,      1, 10, pk(0,0,0), '0, 3'b000);
    vt[12] = mk(0, 0, 0,            0, 0, pk(10,11,0), pd(0, 32'h22, 0), 3'b001);

    // Reset state and first clear.
    step();
    chk("reset_init_done", P*W'(init_done), '0);
    chk("reset_rbusy", P*W'(rbusy), '0);
    chk("reset_rd", rd, '0);
    rst = 1'b0;
    wait_init("clear_cycles", 32);

    // Put a value in reg 5, then confirm reset clears it.
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD;
    step();
    we = 1'b0; ra = pk(5,0,0);
    #1 chk("preload_r5", rd, pd(32'hDEAD, 0, 0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rerun_init_low", P*W'(init_done), '0);
    we = 1'b1; wa = 5'd6; wd = 32'hBEEF; sb_set = 1'b1; sb_addr = 5'd6; ra = pk(5,6,6);
    #1 chk("clear_rd_zero", rd, '0);
    chk("clear_rbusy_zero", P*W'(rbusy), '0);
    step();
    we = 1'b0; sb_set = 1'b0;
    wait_init("clear_cycles_2", 31);
    chk("after_clear_rd", rd, '0);
    chk("after_clear_rbusy", P*W'(rbusy), '0);

    // Reset mid-clear restarts the sequence.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("midclear_init_low", P*W'(init_done), '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_init("midclear_cycles", 32);

    for (int i = 0; i < 13; i++) begin
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
      sb_set = vt[i].sb_set; sb_addr = vt[i].sb_addr; ra = vt[i].ra;
      #1;
      chk($sformatf("vec%0d_rd", i), rd, vt[i].erd);
      chk($sformatf("vec%0d_rbusy", i), P*W'(rbusy), P*W'(vt[i].ebusy));
      step();
    end
    we = 1'b0; sb_set = 1'b0;

    // Bypass versus pre-edge read.
    we = 1'b1; wa = 5'd3; wd = 32'h33; ra = pk(0,0,0);
    step();
    wd = 32'h55; ra = pk(3,0,0);
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("bypass_same_cycle", rd, pd(32'h55, 0, 0));
`else
    chk("bypass_same_cycle", rd, pd(32'h33, 0, 0));
`endif
    step();
    we = 1'b0;
    #1 chk("bypass_next_cycle", rd, pd(32'h55, 0, 0));

    // Reset during RUN drops the scoreboard.
    rst = 1'b1;
    step();
    rst = 1'b0; ra = pk(4,10,9);
    #1 chk("run_reset_init_low", P*W'(init_done), '0);
    wait_init("run_reset_cycles", 32);
    chk("run_reset_rbusy", P*W'(rbusy), '0);
    chk("run_reset_rd", rd, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the RISC-V core, the successor to the single-pair 2R1W file.
- Adds the following:
  - Configurable read-port count.
  - Synchronous active-high reset with a sequenced clear of the array.
  - Per-register busy scoreboard for hazard detection.
  - Optional same-cycle write-to-read bypass.
- Sits between decode (reads, scoreboard issue) and writeback (write port).

Parameters:
- WIDTH, 32: data width of each register in bits.
- REGS, 32: number of architectural registers, 2..64. AW = $clog2(REGS).
- RPORTS, 2: number of combinational read ports, 1..4.
- ZERO_REG, 1: 1 makes register 0 hardwired to zero; 0 makes it an ordinary register.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- init_done  out  1  high once the array clear sequence has finished.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  WIDTH  write data.
- ra  in  RPORTS*AW  packed read addresses; port i is bits [i*AW +: AW].
- rd  out  RPORTS*WIDTH  packed read data; port i is bits [i*WIDTH +: WIDTH].
- rbusy  out  RPORTS  scoreboard busy bit for each read address.
- sb_set  in  1  mark register sb_addr busy (a producer has issued).
- sb_addr  in  AW  scoreboard set address.

Behaviour:
- Reset and clear sequence:
  - Reset is synchronous and active-high. While rst=1 at a clock edge: FSM <= CLEAR, clear counter <= 0, all scoreboard bits <= 0, init_done <= 0.
  - FSM has two states, CLEAR and RUN.
  - In CLEAR, one register per cycle is written to 0 (mem[cnt] <= 0) and cnt increments.
  - When cnt == REGS-1, that last register is cleared and the FSM moves to RUN; init_done = 1 from the next cycle.
  - Clear takes exactly REGS cycles after rst is deasserted.
  - rst asserted mid-clear restarts the clear from register 0.
  - rst asserted during RUN re-enters CLEAR.
- Behaviour while in CLEAR:
  - we and sb_set are ignored.
  - Every rd port reads 0 and every rbusy bit is 0.
- Write port (RUN only):
  - we=1 writes mem[wa] <= wd on the rising edge and clears sb[wa].
  - With ZERO_REG=1, writes to register 0 are dropped; register 0 always reads 0 and is never busy.
  - wa >= REGS (non-power-of-two REGS) is a no-op.
- Read ports:
  - Combinational, zero latency: rd[i] = mem[ra[i]] and rbusy[i] = sb[ra[i]].
  - ra[i] >= REGS reads 0 with busy 0.
  - Multiple ports may read the same address.
- Scoreboard:
  - sb_set=1 in RUN sets sb[sb_addr] <= 1. Register 0 is excluded when ZERO_REG=1.
  - If sb_set and we target the same address in the same cycle, set wins: the data is written and the busy bit ends at 1, because a newer producer is in flight.
  - Different addresses update independently in the same cycle.
- Reset values: init_done=0, rbusy=0, rd=0. Array contents are guaranteed 0 only once init_done=1.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - When we=1 in RUN, wa == ra[i] and wa is not a suppressed zero register, rd[i] returns wd in the same cycle.
  - rbusy[i] reads 0 in that case, unless sb_set targets the same address that cycle.
- Undefined:
  - Reads return the pre-edge array value.
  - The written value is visible from the next cycle.

Test Plan:
- Clear sequence:
  - Stimulus: preload mem[5]=0xDEAD via backdoor, pulse rst for 1 cycle, REGS=32.
  - Response: init_done rises exactly 32 cycles after rst falls; reading reg 5 returns 0x0; a we issued during clear has no effect.
- Reset mid-clear:
  - Stimulus: assert rst again at clear cycle 10.
  - Response: init_done rises 32 cycles after the second rst falls.
- Write/read and zero register, with ZERO_REG=1 and RPORTS=3:
  - Stimulus: write 0x12345678 to reg 7 and 0xFFFFFFFF to reg 0; next cycle read ra={7,0,7}.
  - Response: rd={0x12345678, 0, 0x12345678}.
- Scoreboard:
  - Stimulus: sb_set reg 9, read reg 9, then we reg 9 with data 0xA5.
  - Response: rbusy=1 the cycle after the set and stays 1; after the write edge rbusy=0 and rd=0xA5.
- Scoreboard collision:
  - Stimulus: in the same cycle sb_set reg 4 and we reg 4 with data 0x11.
  - Response: next cycle rd=0x11 and rbusy=1.
- Bypass:
  - Stimulus: we reg 3 with data 0x55 while ra[0]=3.
  - Response: with REGFILE_MP_BYPASS_EN, rd[0]=0x55 in the same cycle; without it, rd[0] holds the old value that cycle and reads 0x55 the next cycle.
